// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // One-hot vector with bit idx set.
  function automatic logic [N_REQ-1:0] onehot8(sel_t idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_1.sv
// Single-bit 8:1 multiplexer, one slice of the shared data path.
module mux8_1 (
  input  logic [7:0] d,
  input  logic [2:0] s,
  output logic       y
);

  assign y = d[s];

endmodule

// File: rtl/mux8_arbiter_rr_pick8.sv
// Combinational round-robin picker: first unmasked requester at or after ptr.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output sel_t             idx
);

  // Scan from the farthest offset down so the nearest candidate to ptr wins.
  always_comb begin
    sel_t cand;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr + sel_t'(k);
      if (req[cand] && !mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter owning one WIDTH-bit 8:1 mux; grants are held for
// multi-cycle transfers and released on done, request drop or hold timeout.
module mux8_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MAX_HOLD = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic                   done,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       grant,
  output sel_t                   sel,
  output logic                   busy,
  output logic [WIDTH-1:0]       data_out,
  output logic                   valid_out,
  output logic                   timeout
);

  // MAX_HOLD=0 disables the timeout; the counter then stays parked at zero.
  localparam int   HC_W      = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int   HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic TMO_EN    = (MAX_HOLD != 0);

  arb_state_t       state_q,    state_d;
  logic [N_REQ-1:0] grant_q,    grant_d;
  sel_t             sel_q,      sel_d;
  logic             busy_q,     busy_d;
  logic             timeout_q,  timeout_d;
  sel_t             ptr_q,      ptr_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic             idle_found;
  sel_t             idle_idx;
  logic             rel_found;
  sel_t             rel_idx;
  sel_t             rel_ptr;
  logic             hold_hit;
  logic             release_now;

  // The re-pick starts just past the releasing owner and excludes it, so it
  // cannot win back the bus on its own release edge.
  assign rel_ptr     = sel_q + sel_t'(1);
  assign hold_hit    = TMO_EN && (hold_cnt_q == HC_W'(HOLD_LAST));
  assign release_now = done || !req[sel_q] || hold_hit;

  rr_pick8 u_pick_idle (
    .req   (req),
    .ptr   (ptr_q),
    .mask  ('0),
    .found (idle_found),
    .idx   (idle_idx)
  );

  rr_pick8 u_pick_rel (
    .req   (req),
    .ptr   (rel_ptr),
    .mask  (onehot8(sel_q)),
    .found (rel_found),
    .idx   (rel_idx)
  );

  // Next-state and registered-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (idle_found) begin
          state_d    = GRANT;
          grant_d    = onehot8(idle_idx);
          sel_d      = idle_idx;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d      = rel_ptr;
          hold_cnt_d = '0;
          // Only a pure hold-limit release is reported; done takes precedence.
          timeout_d  = hold_hit && !done && req[sel_q];
          if (rel_found) begin
            grant_d = onehot8(rel_idx);
            sel_d   = rel_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else if (TMO_EN) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with asynchronous clear so the grant drops immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign valid_out = busy_q & req[sel_q];

  // Bit-sliced data path: one mux8_1 per data bit, all steered by sel.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N_REQ-1:0] column;
    for (genvar j = 0; j < N_REQ; j++) begin : g_src
      assign column[j] = data_in[j*WIDTH + b];
    end
    mux8_1 u_mux (
      .d (column),
      .s (sel_q),
      .y (data_out[b])
    );
  end

endmodule
